// File: rtl/clint_if.sv
// ----------------------------------------------------------------------------
// clint_if
//  Bundles every non-clock, non-reset signal of the core-local interrupt
//  controller.
//  - slave modport:  the clint_ctrl side.
//  - master modport: the pipeline/csr_reg side.
//  Pipeline -> controller:
//    int_flag_i, inst_i, inst_addr_i, jump_flag_i, jump_addr_i, hold_flag_i
//  csr_reg -> controller:
//    global_int_en_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i
//  Controller -> csr_reg:
//    we_o, waddr_o, data_o
//  Controller -> pipeline:
//    hold_flag_o, int_assert_o, int_addr_o
// ----------------------------------------------------------------------------
interface clint_if #(
    parameter int INT_NUM = 8
);
    logic [INT_NUM-1:0] int_flag_i;
    logic [31:0]        inst_i;
    logic [31:0]        inst_addr_i;
    logic               jump_flag_i;
    logic [31:0]        jump_addr_i;
    logic               hold_flag_i;
    logic               global_int_en_i;
    logic [31:0]        csr_mtvec_i;
    logic [31:0]        csr_mepc_i;
    logic [31:0]        csr_mstatus_i;
    logic               we_o;
    logic [31:0]        waddr_o;
    logic [31:0]        data_o;
    logic               hold_flag_o;
    logic               int_assert_o;
    logic [31:0]        int_addr_o;

    modport slave (
        input  int_flag_i, inst_i, inst_addr_i, jump_flag_i, jump_addr_i,
               hold_flag_i, global_int_en_i, csr_mtvec_i, csr_mepc_i,
               csr_mstatus_i,
        output we_o, waddr_o, data_o, hold_flag_o, int_assert_o, int_addr_o
    );

    modport master (
        output int_flag_i, inst_i, inst_addr_i, jump_flag_i, jump_addr_i,
               hold_flag_i, global_int_en_i, csr_mtvec_i, csr_mepc_i,
               csr_mstatus_i,
        input  we_o, waddr_o, data_o, hold_flag_o, int_assert_o, int_addr_o
    );
endinterface

// File: rtl/clint_ctrl.sv
// ----------------------------------------------------------------------------
// clint_ctrl
//  Core-local interrupt/trap controller.
//
//  Function
//  - Detects ecall/ebreak/mret in ex, and masked level interrupts.
//  - Stalls the pipeline while it works.
//  - Writes mepc/mstatus/mcause through the csr_reg write port.
//  - Redirects the PC:
//      - to mtvec on trap entry;
//      - to mepc on mret.
//
//  Ports
//  - clk, rst   : clock; synchronous active-high reset.
//  - bus        : clint_if.slave (pipeline inputs, csr_reg inputs,
//                 CSR write port, stall and redirect outputs).
//
//  Configuration
//  - CLINT_EBREAK_EN defined:   ebreak traps with mcause 3.
//  - CLINT_EBREAK_EN undefined: ebreak is not decoded and passes as a nop.
//
//  Timing (cycle 0 = detect)
//  - Trap: cycle 1 writes mepc, cycle 2 writes mstatus,
//          cycle 3 writes mcause, cycle 4 redirects.
//  - mret: cycle 1 writes mstatus, cycle 2 redirects.
// ----------------------------------------------------------------------------
module clint_ctrl #(
    parameter int          INT_NUM      = 8,
    parameter logic [31:0] MCAUSE_TIMER = 32'h8000_0007,
    parameter logic [31:0] MCAUSE_EXT   = 32'h8000_000B
) (
    input  logic     clk,
    input  logic     rst,
    clint_if.slave   bus
);
    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
    localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
    localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;

    // Each state names what the registered outputs show while in it.
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] W_MEPC    = 3'd1;
    localparam logic [2:0] W_MSTATUS = 3'd2;
    localparam logic [2:0] W_MCAUSE  = 3'd3;
    localparam logic [2:0] R_MSTATUS = 3'd4;
    localparam logic [2:0] ASSERT    = 3'd5;

    logic [2:0]  state_reg,      state_next;
    logic        we_reg,         we_next;
    logic [31:0] waddr_reg,      waddr_next;
    logic [31:0] data_reg,       data_next;
    logic        int_assert_reg, int_assert_next;
    logic [31:0] int_addr_reg,   int_addr_next;
    logic [31:0] cause_reg,      cause_next;

    logic [INT_NUM-1:0] int_flags;
    logic [31:0]        trap_mstatus;
    logic [31:0]        mret_mstatus;
    logic               is_ecall;
    logic               is_ebreak;
    logic               is_mret;
    logic               sync_trap;
    logic               mret_req;
    logic               async_trap;
    logic [31:0]        sync_cause;
    logic [31:0]        async_cause;
    logic [31:0]        async_mepc;
    logic               idle;

    assign int_flags = bus.int_flag_i;

    // mstatus rewrites:
    //   trap entry saves MIE into MPIE and clears MIE;
    //   mret restores MIE from MPIE and sets MPIE.
    for (genvar gi = 0; gi < 32; gi++) begin : g_mstatus
        if (gi == 3) begin : g_mie
            assign trap_mstatus[gi] = 1'b0;
            assign mret_mstatus[gi] = bus.csr_mstatus_i[7];
        end else if (gi == 7) begin : g_mpie
            assign trap_mstatus[gi] = bus.csr_mstatus_i[3];
            assign mret_mstatus[gi] = 1'b1;
        end else begin : g_keep
            assign trap_mstatus[gi] = bus.csr_mstatus_i[gi];
            assign mret_mstatus[gi] = bus.csr_mstatus_i[gi];
        end
    end

    assign is_ecall = (bus.inst_i == INST_ECALL);
`ifdef CLINT_EBREAK_EN
    assign is_ebreak = (bus.inst_i == INST_EBREAK);
`else
    assign is_ebreak = 1'b0;
`endif
    assign is_mret = (bus.inst_i == INST_MRET);

    // Priority: sync trap > mret > async.
    // A losing async request is a level, so it is simply seen again later.
    assign sync_trap  = is_ecall | is_ebreak;
    assign mret_req   = is_mret & ~sync_trap;
    assign async_trap = (|int_flags) & bus.global_int_en_i & ~bus.hold_flag_i
                        & ~sync_trap & ~is_mret;

    assign sync_cause  = is_ebreak ? 32'd3 : 32'd11;
    assign async_cause = int_flags[0] ? MCAUSE_TIMER : MCAUSE_EXT;

    // An interrupt taken while ex redirects must resume at the redirect target.
    assign async_mepc = bus.jump_flag_i ? bus.jump_addr_i : bus.inst_addr_i;

    assign idle = (state_reg == IDLE);

    // Stall is combinational so ex drops its own CSR write in the detect cycle.
    assign bus.hold_flag_o = ~rst
                           & (~idle | sync_trap | mret_req | async_trap);

    always_comb begin
        state_next      = state_reg;
        we_next         = 1'b0;
        waddr_next      = 32'd0;
        data_next       = 32'd0;
        int_assert_next = 1'b0;
        int_addr_next   = 32'd0;
        cause_next      = cause_reg;
        case (state_reg)
            IDLE: begin
                if (sync_trap) begin
                    state_next = W_MEPC;
                    we_next    = 1'b1;
                    waddr_next = CSR_MEPC;
                    data_next  = bus.inst_addr_i;
                    cause_next = sync_cause;
                end else if (mret_req) begin
                    state_next = R_MSTATUS;
                    we_next    = 1'b1;
                    waddr_next = CSR_MSTATUS;
                    data_next  = mret_mstatus;
                end else if (async_trap) begin
                    state_next = W_MEPC;
                    we_next    = 1'b1;
                    waddr_next = CSR_MEPC;
                    data_next  = async_mepc;
                    cause_next = async_cause;
                end
            end
            W_MEPC: begin
                state_next = W_MSTATUS;
                we_next    = 1'b1;
                waddr_next = CSR_MSTATUS;
                data_next  = trap_mstatus;
            end
            W_MSTATUS: begin
                state_next = W_MCAUSE;
                we_next    = 1'b1;
                waddr_next = CSR_MCAUSE;
                data_next  = cause_reg;
            end
            W_MCAUSE: begin
                state_next      = ASSERT;
                int_assert_next = 1'b1;
                int_addr_next   = bus.csr_mtvec_i;
            end
            R_MSTATUS: begin
                state_next      = ASSERT;
                int_assert_next = 1'b1;
                int_addr_next   = bus.csr_mepc_i;
            end
            ASSERT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            we_reg         <= 1'b0;
            waddr_reg      <= 32'd0;
            data_reg       <= 32'd0;
            int_assert_reg <= 1'b0;
            int_addr_reg   <= 32'd0;
            cause_reg      <= 32'd0;
        end else begin
            state_reg      <= state_next;
            we_reg         <= we_next;
            waddr_reg      <= waddr_next;
            data_reg       <= data_next;
            int_assert_reg <= int_assert_next;
            int_addr_reg   <= int_addr_next;
            cause_reg      <= cause_next;
        end
    end

    assign bus.we_o         = we_reg;
    assign bus.waddr_o      = waddr_reg;
    assign bus.data_o       = data_reg;
    assign bus.int_assert_o = int_assert_reg;
    assign bus.int_addr_o   = int_addr_reg;
endmodule

// File: tb/tb_clint_ctrl.sv
// ----------------------------------------------------------------------------
// tb_clint_ctrl
//  Drives clint_ctrl through directed scenarios and then random traffic.
//
//  Reference model
//  - Emulates csr_reg (mepc/mstatus/mcause/mtvec), updated from the
//    expected writes.
//  - When a trap or mret is recognised, pushes the whole expected output
//    sequence, one entry per cycle, into a queue.
//
//  Each cycle, the registered outputs are compared against the queue head
//  and hold_flag_o is compared against busy-or-detect.
// ----------------------------------------------------------------------------
module tb_clint_ctrl;
    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;
`ifdef CLINT_EBREAK_EN
    localparam bit EBREAK_EN = 1'b1;
`else
    localparam bit EBREAK_EN = 1'b0;
`endif

    typedef struct packed {
        logic        we;
        logic [31:0] waddr;
        logic [31:0] data;
        logic        as;
        logic [31:0] aaddr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    clint_if #(.INT_NUM(8)) bus ();

    clint_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t        q[$];
    logic [31:0] mepc_m, mstatus_m, mcause_m, mtvec_m;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle.
    //  - Called at posedge+1.
    //  - Checks this cycle's registered outputs, then drives the inputs.
    //  - Checks the stall, then updates the model.
    task automatic step(input logic [31:0] inst, input logic [31:0] pc,
                        input logic [7:0] irq, input logic jf,
                        input logic [31:0] ja, input logic hf, input logic rv);
        exp_t        cur;
        logic        busy, det, sync_t, mret_t, async_t;
        logic [31:0] cause, mst;
        busy = (q.size() != 0);
        cur  = '0;
        if (busy) cur = q.pop_front();
        chk("we_o", {31'd0, bus.we_o}, {31'd0, cur.we});
        chk("int_assert_o", {31'd0, bus.int_assert_o}, {31'd0, cur.as});
        if (cur.we) begin
            chk("waddr_o", bus.waddr_o, cur.waddr);
            chk("data_o", bus.data_o, cur.data);
        end
        if (cur.as) chk("int_addr_o", bus.int_addr_o, cur.aaddr);

        bus.inst_i          = inst;
        bus.inst_addr_i     = pc;
        bus.int_flag_i      = irq;
        bus.jump_flag_i     = jf;
        bus.jump_addr_i     = ja;
        bus.hold_flag_i     = hf;
        bus.global_int_en_i = mstatus_m[3];
        bus.csr_mstatus_i   = mstatus_m;
        bus.csr_mepc_i      = mepc_m;
        bus.csr_mtvec_i     = mtvec_m;
        rst                 = rv;
        #1;

        sync_t  = (inst == ECALL) || (EBREAK_EN && inst == EBREAK);
        cause   = (inst == ECALL) ? 32'd11 : 32'd3;
        mret_t  = !sync_t && inst == MRET;
        async_t = !sync_t && !mret_t && irq != 8'd0 && mstatus_m[3] && !hf;
        det     = !rv && !busy && (sync_t || mret_t || async_t);
        chk("hold_flag_o", {31'd0, bus.hold_flag_o}, {31'd0, !rv && (busy || det)});

        mst = mstatus_m;
        if (det && mret_t) begin
            q.push_back('{1'b1, 32'h300,
                          (mst & ~32'h88) | 32'h80 | (mst[7] ? 32'h8 : 32'h0),
                          1'b0, 32'd0});
            q.push_back('{1'b0, 32'd0, 32'd0, 1'b1, mepc_m});
        end else if (det) begin
            if (async_t) cause = irq[0] ? 32'h8000_0007 : 32'h8000_000B;
            q.push_back('{1'b1, 32'h341, (async_t && jf) ? ja : pc, 1'b0, 32'd0});
            q.push_back('{1'b1, 32'h300,
                          (mst & ~32'h88) | (mst[3] ? 32'h80 : 32'h0),
                          1'b0, 32'd0});
            q.push_back('{1'b1, 32'h342, cause, 1'b0, 32'd0});
            q.push_back('{1'b0, 32'd0, 32'd0, 1'b1, mtvec_m});
        end

        if (cur.we) begin
            case (cur.waddr)
                32'h341: mepc_m    = cur.data;
                32'h300: mstatus_m = cur.data;
                32'h342: mcause_m  = cur.data;
                default: ;
            endcase
        end
        if (rv) q.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        repeat (n) step(NOP, 32'h1000, 8'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        mepc_m    = 32'd0;
        mstatus_m = 32'h8;
        mcause_m  = 32'd0;
        mtvec_m   = 32'h200;

        bus.inst_i          = NOP;
        bus.inst_addr_i     = 32'd0;
        bus.int_flag_i      = 8'd0;
        bus.jump_flag_i     = 1'b0;
        bus.jump_addr_i     = 32'd0;
        bus.hold_flag_i     = 1'b0;
        bus.global_int_en_i = 1'b0;
        bus.csr_mtvec_i     = 32'd0;
        bus.csr_mepc_i      = 32'd0;
        bus.csr_mstatus_i   = 32'd0;

        @(posedge clk);
        #1;
        chk("rst_waddr_o", bus.waddr_o, 32'd0);
        chk("rst_data_o", bus.data_o, 32'd0);
        chk("rst_int_addr_o", bus.int_addr_o, 32'd0);
        step(ECALL, 32'h100, 8'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        step(NOP, 32'h0, 8'd0, 1'b0, 32'd0, 1'b0, 1'b1);

        // Scenario: ecall at 0x100, mtvec 0x200, MIE=1.
        step(ECALL, 32'h100, 8'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        drain(5);
        step(MRET, 32'h204, 8'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        drain(3);

        // Scenario: timer interrupt while ex jumps to 0x80.
        step(NOP, 32'h300, 8'h01, 1'b1, 32'h80, 1'b0, 1'b0);
        drain(5);
        step(MRET, 32'h204, 8'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        drain(3);

        // Scenario: external interrupt masked by MIE=0, then by hold_flag_i.
        mstatus_m = 32'h0;
        repeat (3) step(NOP, 32'h400, 8'h04, 1'b0, 32'd0, 1'b0, 1'b0);
        mstatus_m = 32'h8;
        repeat (3) step(NOP, 32'h404, 8'h04, 1'b0, 32'd0, 1'b1, 1'b0);
        step(NOP, 32'h408, 8'h04, 1'b0, 32'd0, 1'b0, 1'b0);
        drain(5);

        // Scenario: mret with mepc=0x104 and mstatus=0x80.
        mepc_m    = 32'h104;
        mstatus_m = 32'h80;
        step(MRET, 32'h500, 8'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        drain(3);

        // Scenario: ecall and timer interrupt together.
        step(ECALL, 32'h600, 8'h01, 1'b0, 32'd0, 1'b0, 1'b0);
        repeat (4) step(NOP, 32'h604, 8'h01, 1'b0, 32'd0, 1'b0, 1'b0);
        step(MRET, 32'h208, 8'h01, 1'b0, 32'd0, 1'b0, 1'b0);
        repeat (7) step(NOP, 32'h604, 8'h01, 1'b0, 32'd0, 1'b0, 1'b0);
        step(MRET, 32'h20c, 8'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        drain(3);

        // Scenario: reset while the mstatus write is on the port.
        step(ECALL, 32'h700, 8'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        step(NOP, 32'h700, 8'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        step(NOP, 32'h700, 8'd0, 1'b0, 32'd0, 1'b0, 1'b1);
        drain(4);

        // Scenario: ebreak (trap or nop depending on build).
        mstatus_m = 32'h8;
        step(EBREAK, 32'h800, 8'd0, 1'b0, 32'd0, 1'b0, 1'b0);
        drain(5);

        // Random traffic.
        mtvec_m = $urandom & 32'hFFFF_FFFC;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] inst;
            logic [7:0]  irq;
            int          r;
            r = int'($urandom_range(0, 15));
            if (r < 2)       inst = ECALL;
            else if (r == 2) inst = EBREAK;
            else if (r < 5)  inst = MRET;
            else if (r < 10) inst = NOP;
            else             inst = $urandom;
            irq = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd0;
            step(inst, $urandom & 32'hFFFF_FFFC, irq,
                 $urandom_range(0, 2) == 0, $urandom & 32'hFFFF_FFFC,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 199) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
